exe_muldiv: RTL

Iterative multiply/divide unit in the EXE stage. It consumes the operand and control fields latched by the ID/EXE pipeline register and owns the architectural HI/LO registers. It executes mult, multu, div and divu over 33 clocks. While busy it holds a stall request to the hazard unit, so mfhi, mflo, mthi, mtlo and new mul/div instructions wait until it is idle.

---
 rtl/exe_muldiv_if.sv | 25 ++
 rtl/exe_muldiv.sv | 138 +++++++++++++
 2 files changed

// File: rtl/exe_muldiv_if.sv
// ID/EXE-side bundle for the iterative mul/div unit: operands and control in, HI/LO and status out.
// master = pipeline/hazard side, slave = exe_muldiv.
interface exe_muldiv_if;
  logic [31:0] EXE_q1;
  logic [31:0] EXE_q2;
  logic        EXE_md_start;
  logic [1:0]  EXE_md_op;
  logic        EXE_bubble;
  logic        EXE_hi_we;
  logic        EXE_lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output EXE_q1, EXE_q2, EXE_md_start, EXE_md_op, EXE_bubble, EXE_hi_we, EXE_lo_we,
    input  hi, lo, busy, done
  );

  modport slave (
    input  EXE_q1, EXE_q2, EXE_md_start, EXE_md_op, EXE_bubble, EXE_hi_we, EXE_lo_we,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative mult/multu/div/divu owning HI/LO; result 33 clocks after accept, done pulses with new HI/LO.
// No input handshake: busy (registered state != IDLE) stalls the pipeline, and inputs outside IDLE are ignored.
module exe_muldiv (
  input  logic         clock,
  input  logic         reset,
  exe_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand for mul, divisor for div
  logic [63:0] acc_q, acc_d;     // product for mul; low half is dividend/quotient for div
  logic [31:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_signed;
  logic        accept;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign in_signed = ~bus.EXE_md_op[0];
  assign accept    = (state_q == IDLE) && bus.EXE_md_start && !bus.EXE_bubble;
  assign a_abs     = (in_signed && bus.EXE_q1[31]) ? (~bus.EXE_q1 + 32'd1) : bus.EXE_q1;
  assign b_abs     = (in_signed && bus.EXE_q2[31]) ? (~bus.EXE_q2 + 32'd1) : bus.EXE_q2;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = {rem_q, acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  assign prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
  // A zero divisor leaves an all-ones quotient that must not be sign-corrected;
  // the remainder restores to |A|, so re-applying A's sign yields the original operand.
  assign quo_fix   = (neg_q && !dz_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          div_d   = bus.EXE_md_op[1];
          opnd_d  = bus.EXE_md_op[1] ? b_abs : a_abs;
          acc_d   = {32'd0, bus.EXE_md_op[1] ? a_abs : b_abs};
          rem_d   = 32'd0;
          neg_d   = in_signed & (bus.EXE_q1[31] ^ bus.EXE_q2[31]);
          rneg_d  = in_signed & bus.EXE_q1[31];
          dz_d    = bus.EXE_md_op[1] & (bus.EXE_q2 == 32'd0);
          cnt_d   = 6'd0;
          state_d = RUN;
        end else if (!bus.EXE_bubble) begin
          if (bus.EXE_hi_we) hi_d = bus.EXE_q1;
          if (bus.EXE_lo_we) lo_d = bus.EXE_q1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (div_q) begin
          acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
          rem_d = div_ge ? 32'(div_shift - {1'b0, opnd_q}) : div_shift[31:0];
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      div_q   <= 1'b0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule
